// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: N-digit double-buffered seven-segment scanner with leading-zero blanking;
// defining SSD_BLINK_EN adds the BlinkMask port and per-digit blinking.
module ssd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 18
`ifdef SSD_BLINK_EN
  , parameter int BLINK_FRAMES = 5
`endif
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [4*N_DIGITS-1:0] Value,
  input  logic [N_DIGITS-1:0]   DpMask,
  input  logic                  Load,
  input  logic                  BlankLz,
`ifdef SSD_BLINK_EN
  input  logic [N_DIGITS-1:0]   BlinkMask,
`endif
  output logic [N_DIGITS-1:0]   An,
  output logic [7:0]            Cathodes,
  output logic                  FrameTick,
  output logic                  LoadPending
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

  logic [SCAN_DIV-1:0]   presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                  pend_q, pend_d;
  logic                  wrap_q, ft_q;
  logic [N_DIGITS-1:0]   an_q, an_d, sel;
  logic [7:0]            cath_q, cath_d;
  logic                  tick, wrap, xfer, nz, bl, blank, dp;
  logic [3:0]            nib;

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Transfer to the active buffer only at the frame wrap, using pre-edge pending contents.
  always_comb begin
    tick       = &presc_q;
    wrap       = tick && (idx_q == LAST);
    xfer       = wrap && pend_q;
    presc_d    = presc_q + 1'b1;
    idx_d      = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
    act_val_d  = xfer ? pend_val_q : act_val_q;
    act_dp_d   = xfer ? pend_dp_q : act_dp_q;
    pend_val_d = Load ? Value : pend_val_q;
    pend_dp_d  = Load ? DpMask : pend_dp_q;
    pend_d     = Load || (pend_q && !wrap);
  end

`ifdef SSD_BLINK_EN
  logic [BLINK_FRAMES-1:0] bcnt_q;
  logic                    phase_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      bcnt_q  <= bcnt_q + 1'b1;
      phase_q <= phase_q ^ (&bcnt_q);
    end
`endif

  always_comb begin
    nib = '0;
    dp  = 1'b0;
    sel = '0;
    nz  = 1'b0;
    bl  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) <= idx_q && act_val_q[4*(N_DIGITS-1-i) +: 4] != 4'd0) nz = 1'b1;
      if (IW'(i) == idx_q) begin
        nib                 = act_val_q[4*(N_DIGITS-1-i) +: 4];
        dp                  = act_dp_q[N_DIGITS-1-i];
        sel[N_DIGITS-1-i]   = 1'b1;
`ifdef SSD_BLINK_EN
        bl                  = phase_q && BlinkMask[N_DIGITS-1-i];
`endif
      end
    end
    blank  = bl || (BlankLz && !nz && idx_q != LAST);
    an_d   = blank ? '1 : ~sel;
    cath_d = blank ? 8'hFF : {font(nib), ~dp};
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
      ft_q       <= 1'b0;
      an_q       <= '1;
      cath_q     <= 8'hFF;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      wrap_q     <= wrap;
      ft_q       <= wrap_q;
      an_q       <= an_d;
      cath_q     <= cath_d;
    end

  assign An          = an_q;
  assign Cathodes    = cath_q;
  assign FrameTick   = ft_q;
  assign LoadPending = pend_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed checks of ssd_scan_ctrl with N_DIGITS=4, SCAN_DIV=2.
module tb_ssd_scan_ctrl;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] Value = '0;
  logic [3:0]  DpMask = '0;
  logic        Load = 1'b0;
  logic        BlankLz = 1'b0;
  logic [3:0]  An;
  logic [7:0]  Cathodes;
  logic        FrameTick, LoadPending;
  int          checks = 0;
  int          failures = 0;
`ifdef SSD_BLINK_EN
  logic [3:0]  BlinkMask = '0;
`endif

  ssd_scan_ctrl #(
    .N_DIGITS(4),
    .SCAN_DIV(2)
`ifdef SSD_BLINK_EN
    , .BLINK_FRAMES(1)
`endif
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Value(Value),
    .DpMask(DpMask),
    .Load(Load),
    .BlankLz(BlankLz),
`ifdef SSD_BLINK_EN
    .BlinkMask(BlinkMask),
`endif
    .An(An),
    .Cathodes(Cathodes),
    .FrameTick(FrameTick),
    .LoadPending(LoadPending)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    Value  = v;
    DpMask = dp;
    Load   = 1'b1;
    step(1);
    Load   = 1'b0;
  endtask

  task automatic wait_ft();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (FrameTick !== 1'b1 && n < 40);
    chk("ft_wait", 8'(FrameTick), 8'h01);
  endtask

  task automatic show_frame(input string tag, input logic [15:0] an_s, input logic [31:0] ca_s,
                            input logic lp0);
    for (int c = 0; c < 16; c++) begin
      chk({tag, "_an"}, 8'(An), 8'(an_s[15-4*(c/4) -: 4]));
      chk({tag, "_ca"}, Cathodes, ca_s[31-8*(c/4) -: 8]);
      chk({tag, "_ft"}, 8'(FrameTick), 8'(c == 0));
      if (c == 0) chk({tag, "_lp"}, 8'(LoadPending), 8'(lp0));
      step(1);
    end
  endtask

  initial begin
    @(negedge Clk);
    step(2);
    chk("rst_an", 8'(An), 8'h0F);
    chk("rst_ca", Cathodes, 8'hFF);
    chk("rst_ft", 8'(FrameTick), 8'h00);
    chk("rst_lp", 8'(LoadPending), 8'h00);
    Reset_n = 1'b1;
    do_load(16'h12AF, 4'b0000);
    chk("first_an", 8'(An), 8'h07);
    chk("first_ca", Cathodes, 8'h03);
    chk("first_lp", 8'(LoadPending), 8'h01);
    wait_ft();
    show_frame("f12af", 16'h7BDE, 32'h9F251171, 1'b0);
    do_load(16'h4D70, 4'b0101);
    wait_ft();
    show_frame("f4d70", 16'h7BDE, 32'h99841F02, 1'b0);
    do_load(16'hBCE6, 4'b0000);
    wait_ft();
    show_frame("fbce6", 16'h7BDE, 32'hC1636141, 1'b0);
    BlankLz = 1'b1;
    do_load(16'h0005, 4'b0000);
    wait_ft();
    show_frame("lz0005", 16'hFFFE, 32'hFFFFFF49, 1'b0);
    do_load(16'h0000, 4'b0000);
    wait_ft();
    show_frame("lz0000", 16'hFFFE, 32'hFFFFFF03, 1'b0);
    do_load(16'h0105, 4'b0000);
    wait_ft();
    show_frame("lz0105", 16'hFBDE, 32'hFF9F0349, 1'b0);
    BlankLz = 1'b0;
    wait_ft();
    fork
      show_frame("dbuf_old", 16'h7BDE, 32'h039F0349, 1'b0);
      begin
        step(5);
        do_load(16'h1111, 4'b0000);
        chk("dbuf_lp", 8'(LoadPending), 8'h01);
        step(1);
        do_load(16'h2222, 4'b0000);
      end
    join
    show_frame("dbuf_new", 16'h7BDE, 32'h25252525, 1'b0);
    step(15);
    do_load(16'h3333, 4'b0000);
    show_frame("sim_old", 16'h7BDE, 32'h25252525, 1'b1);
    show_frame("sim_new", 16'h7BDE, 32'h0D0D0D0D, 1'b0);
    do_load(16'h4444, 4'b0000);
    step(8);
    chk("pre_rst_an", 8'(An), 8'h0D);
    chk("pre_rst_lp", 8'(LoadPending), 8'h01);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_an", 8'(An), 8'h0F);
    chk("mid_rst_ca", Cathodes, 8'hFF);
    chk("mid_rst_lp", 8'(LoadPending), 8'h00);
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_ft();
    show_frame("post_rst", 16'h7BDE, 32'h03030303, 1'b0);
`ifdef SSD_BLINK_EN
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n   = 1'b1;
    BlinkMask = 4'b0001;
    do_load(16'h1234, 4'b0000);
    wait_ft();
    show_frame("blink_f1", 16'h7BDE, 32'h9F250D99, 1'b0);
    show_frame("blink_f2", 16'h7BDF, 32'h9F250DFF, 1'b0);
    show_frame("blink_f3", 16'h7BDF, 32'h9F250DFF, 1'b0);
    show_frame("blink_f4", 16'h7BDE, 32'h9F250D99, 1'b0);
    show_frame("blink_f5", 16'h7BDE, 32'h9F250D99, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Parametrised N-digit seven-segment scan controller. It replaces the fixed 4-digit, 2-bit scan mux and hex decoder in the game top level. It adds:
- double-buffered display loads, so a digit never tears mid-frame;
- leading-zero blanking;
- per-digit decimal points;
- an optional blink mode.

It sits between the game datapath (score and number registers) and the board anode/cathode pins.

## Interface
Parameters:
- N_DIGITS, 4, number of digits scanned (1..8)
- SCAN_DIV, 18, log2 of Clk cycles each digit is lit (2^18 at 100 MHz = 2.62 ms)
- BLINK_FRAMES, 5, log2 of frames per blink half-period (used only with SSD_BLINK_EN)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- Value  in  4*N_DIGITS  hex digits to display; most significant nibble is the leftmost digit
- DpMask  in  N_DIGITS  decimal-point enables; bit N_DIGITS-1 is the leftmost digit; 1 = point lit
- Load  in  1  single-cycle strobe that captures Value and DpMask into the pending buffer
- BlankLz  in  1  1 = blank leading zeros
- BlinkMask  in  N_DIGITS  per-digit blink enable; present only with SSD_BLINK_EN
- An  out  N_DIGITS  anodes, active-low; An[N_DIGITS-1] is the leftmost digit
- Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
- FrameTick  out  1  one-cycle pulse at each frame wrap
- LoadPending  out  1  1 while the pending buffer holds data not yet displayed

## Operation
- Prescaler: a SCAN_DIV-bit up-counter. When it reaches all-ones, digit index idx advances (0 = leftmost) and the prescaler wraps to 0.
- Index wrap: idx runs 0..N_DIGITS-1 and returns to 0.
  - The transition N_DIGITS-1 → 0 is the frame wrap.
  - At the frame wrap, if LoadPending=1: active buffer <= pending buffer and LoadPending <= 0.
- Load:
  - On Load=1, pending <= {Value, DpMask} and LoadPending <= 1.
  - A Load while LoadPending=1 overwrites pending. The latest value wins.
- Load coinciding with a frame wrap:
  - The transfer uses the pending contents from before the edge.
  - The new data is written to pending, and LoadPending stays 1.
  - If nothing was pending before that edge, nothing transfers at that wrap.
- Digit selection: the digit at idx shows nibble active[4*(N_DIGITS-1-idx) +: 4]. Its anode is An[N_DIGITS-1-idx] = 0; all other anodes are 1.
- Hex font, {a..g} active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Decimal point: Dp = ~DpMask bit of the current digit.
- Leading-zero blanking: applies when BlankLz=1 and every active nibble from the leftmost digit through the current digit is 0.
  - A blanked digit drives its anode to 1 and Cathodes to 8'hFF.
  - The rightmost digit is never blanked.
- All outputs are registered.

## Timing
- Reset (Reset_n=0, asynchronous):
  - prescaler=0, idx=0, active=0, pending=0, LoadPending=0;
  - An=all ones, Cathodes=8'hFF, FrameTick=0.
- First edge after release: An and Cathodes reflect idx=0.
- Output latency: An and Cathodes update 1 cycle after an idx change.
- Dwell and frame length: each digit is lit for 2^SCAN_DIV cycles; a frame is N_DIGITS*2^SCAN_DIV cycles.
- FrameTick: high for exactly 1 cycle, aligned with the output update for idx=0.
- Load-to-display latency: at most one frame plus 1 cycle. A partially scanned frame always finishes with the old data.
- Reset mid-frame: outputs go dark immediately, and any pending load is discarded.

## Configuration
- SSD_BLINK_EN defined:
  - Adds the BlinkMask port and a BLINK_FRAMES-bit frame counter.
  - A blink phase bit toggles each time the counter wraps; the counter and phase reset to 0.
  - While phase=1, digits with their BlinkMask bit set are blanked, exactly as for leading-zero blanking.
- SSD_BLINK_EN undefined: no BlinkMask port, no frame counter, no blinking.

## Test plan
All scenarios use N_DIGITS=4 and SCAN_DIV=2.
- Reset and first load: hold Reset_n=0, then release and pulse Load with Value=16'h12AF, DpMask=0.
  - Required: during reset, An=4'b1111 and Cathodes=8'hFF.
  - After the next FrameTick, the display cycles An=0111/1011/1101/1110 with Cathodes=10011111/00100101/00010001/01110001.
- Dwell: An changes every 4 cycles; FrameTick pulses for 1 cycle every 16 cycles.
- Leading-zero blanking: BlankLz=1.
  - Value=16'h0005: An1..An3 stay high; the rightmost digit shows 01001001.
  - Value=16'h0000: only the rightmost digit is lit, showing 00000011.
  - Value=16'h0105: only the leftmost digit is blanked.
- Double buffer: Load 16'h1111 mid-frame, then Load 16'h2222 two cycles later.
  - Required: the rest of the current frame shows the old data; the next frame shows all 2s and never a 1; LoadPending drops at the wrap.
- Simultaneous events and reset: assert Load on the frame-wrap edge with nothing pending, and separately drop Reset_n while idx=2.
  - Required: the Load data appears one frame later; the reset immediately gives An=1111 with LoadPending=0.
- Blink (SSD_BLINK_EN defined, BLINK_FRAMES=1): BlinkMask=4'b0001.
  - Required: the rightmost digit is dark for 2 frames and lit for 2 frames, alternating; the other digits are unaffected.
